// File: rtl/icache_responder_pkg.sv
// Shared types for the IF-stage instruction cache: line/word types, cache address
// fields for the default geometry, and the fill FSM state encoding.
package icache_responder_pkg;
  localparam int LC3B_LINE_WORDS = 8;
  localparam int C_NUM_SETS      = 8;
  localparam int C_INDEX_W       = $clog2(C_NUM_SETS);
  localparam int C_TAG_W         = 12 - C_INDEX_W;

  typedef logic [15:0]           lc3b_word;
  typedef logic [127:0]          lc3b_line;
  typedef logic [C_TAG_W-1:0]    lc3b_c_tag;
  typedef logic [C_INDEX_W-1:0]  lc3b_c_index;
  typedef logic [3:0]            lc3b_c_offset;

  typedef enum logic {IDLE, FILL} icache_state_e;
endpackage

// File: rtl/icache_responder_if.sv
// Fetch port (IF stage -> cache) and line-fill port (cache -> memory arbiter).
interface icache_responder_if;
  import icache_responder_pkg::*;

  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  lc3b_word    rdata_a;
  logic        pmem_read;
  logic [15:0] pmem_address;
  logic        pmem_resp;
  lc3b_line    pmem_rdata;

  modport slave (
    input  read_a, address_a, pmem_resp, pmem_rdata,
    output resp_a, rdata_a, pmem_read, pmem_address
  );
  modport master (
    output read_a, address_a, pmem_resp, pmem_rdata,
    input  resp_a, rdata_a, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_responder_array.sv
// Tag/valid/data storage: combinational read by index, synchronous single write port.
// Reset clears only the valid bits; tag and data contents are don't-care until filled.
module icache_responder_array #(
  parameter int NUM_SETS  = 8,
  parameter int TAG_W     = 9,
  parameter int LINE_BITS = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_SETS)-1:0] rd_idx,
  output logic                        rd_valid,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [LINE_BITS-1:0]        rd_line,
  input  logic                        we,
  input  logic [$clog2(NUM_SETS)-1:0] wr_idx,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [LINE_BITS-1:0]        wr_line
);
  logic [NUM_SETS-1:0]  valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_SETS];
  logic [LINE_BITS-1:0] data_arr [NUM_SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_line  = data_arr[rd_idx];

  always_ff @(posedge clk) begin
    if (rst)     valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_arr[wr_idx]  <= wr_tag;
      data_arr[wr_idx] <= wr_line;
    end
  end
endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-wait hits, one outstanding line fill
// that always runs to completion once issued to the arbiter.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int NUM_SETS  = C_NUM_SETS,
  parameter int LINE_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  icache_responder_if.slave   bus,
  input  logic                count_reset,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  icache_state_e        state;
  logic [15:0]          fill_addr;
  logic [15:0]          hit_cnt;
  logic [15:0]          miss_cnt;
  logic [TW-1:0]        req_tag;
  logic [IW-1:0]        req_idx;
  logic [2:0]           req_word;
  logic                 rd_valid;
  logic [TW-1:0]        rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 hit, miss_start, fill_done;
  logic                 unused_a0;

  assign req_tag   = bus.address_a[15:4+IW];
  assign req_idx   = bus.address_a[3+IW:4];
  assign req_word  = bus.address_a[3:1];
  assign unused_a0 = bus.address_a[0];

  icache_responder_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TW),
    .LINE_BITS(LINE_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .we      (fill_done),
    .wr_idx  (fill_addr[3+IW:4]),
    .wr_tag  (fill_addr[15:4+IW]),
    .wr_line (bus.pmem_rdata)
  );

  // Lookups only count in IDLE: during a fill the array may be about to change under us.
  assign hit         = bus.read_a & rd_valid & (rd_tag == req_tag);
  assign bus.resp_a  = (state == IDLE) & hit & ~rst;
  assign bus.rdata_a = rd_line[{req_word, 4'b0000} +: 16];
  assign miss_start  = (state == IDLE) & bus.read_a & ~hit & ~rst;
  assign fill_done   = (state == FILL) & bus.pmem_resp & ~rst;

  assign bus.pmem_address = fill_addr;
  assign hit_count        = hit_cnt;
  assign miss_count       = miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fill_addr     <= '0;
      bus.pmem_read <= 1'b0;
    end else begin
      case (state)
        IDLE: if (miss_start) begin
          fill_addr     <= {bus.address_a[15:4], 4'b0000};
          bus.pmem_read <= 1'b1;
          state         <= FILL;
        end
        FILL: if (bus.pmem_resp) begin
          bus.pmem_read <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || count_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (bus.resp_a) hit_cnt  <= hit_cnt + 16'd1;
      if (miss_start) miss_cnt <= miss_cnt + 16'd1;
    end
  end
endmodule
